// File: rtl/wb_pkg.sv
// Shared register-file write-back types and constants.
package wb_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam int REG_AW       = 5;
  localparam int REG_NUM      = 32;
  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_AW-1:0]       rd;
    logic [XLEN_DEFAULT-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO, power-of-two depth; push on full and pop on empty are ignored.
// Head entry is visible combinationally; count/full/empty come from registers.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [AW:0]      count_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write port arbiter: load returns > buffered execute > direct execute, 1-cycle registered write.
// Execute side is valid/ready (ready from registered FIFO count); REGFILE_WB_FWD_EN adds early forwarding outputs.
module regfile_wb_ctrl
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = XLEN_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [4:0]        ex_rd_i,
  input  logic [XLEN-1:0]   ex_data_i,
  input  logic              ld_valid_i,
  input  logic [4:0]        ld_rd_i,
  input  logic [XLEN-1:0]   ld_data_i,
  input  logic              ld_issue_i,
  input  logic [4:0]        ld_issue_rd_i,
  output logic [31:0]       busy_o,
  output logic              reg_wen_o,
  output logic [4:0]        reg_waddr_o,
  output logic [XLEN-1:0]   reg_wdata_o
`ifdef REGFILE_WB_FWD_EN
  ,
  output logic              fwd_valid_o,
  output logic [4:0]        fwd_addr_o,
  output logic [XLEN-1:0]   fwd_data_o
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } entry_t;

  entry_t              ex_entry, head, sel;
  logic [CW-1:0]       fifo_count;
  logic                fifo_full, fifo_empty;
  logic                push, pop, ex_acc, sel_vld, sel_wen;
  logic                wen_q, wen_d;
  logic [REG_AW-1:0]   waddr_q, waddr_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [REG_NUM-1:0]  busy_q, busy_d;

  assign ex_entry.rd   = ex_rd_i;
  assign ex_entry.data = ex_data_i;
  // Ready comes only from registered count so a pop never feeds back into ready.
  assign ex_ready_o    = rst & (fifo_count < DEPTH_CNT);
  assign ex_acc        = ex_valid_i & ex_ready_o;

  wb_fifo #(.DEPTH(DEPTH), .WIDTH($bits(entry_t))) u_ex_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push & ~fifo_full),
    .wdata_i (ex_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    push    = 1'b0;
    pop     = 1'b0;
    sel_vld = 1'b0;
    sel     = ex_entry;
    if (ld_valid_i) begin
      sel_vld   = 1'b1;
      sel.rd    = ld_rd_i;
      sel.data  = ld_data_i;
      push      = ex_acc;
    end else if (!fifo_empty) begin
      sel_vld = 1'b1;
      sel     = head;
      pop     = 1'b1;
      push    = ex_acc;
    end else if (ex_acc) begin
      sel_vld = 1'b1;
    end
    // x0 results still consume their turn but never reach the port.
    sel_wen = sel_vld && (sel.rd != ZERO_REG);
    wen_d   = sel_wen;
    waddr_d = sel_wen ? sel.rd   : waddr_q;
    wdata_d = sel_wen ? sel.data : wdata_q;

    busy_d = busy_q;
    if (ld_valid_i) busy_d[ld_rd_i] = 1'b0;
    if (ld_issue_i && (ld_issue_rd_i != ZERO_REG)) busy_d[ld_issue_rd_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign reg_wen_o   = wen_q;
  assign reg_waddr_o = waddr_q;
  assign reg_wdata_o = wdata_q;
  assign busy_o      = busy_q;

`ifdef REGFILE_WB_FWD_EN
  assign fwd_valid_o = sel_wen;
  assign fwd_addr_o  = sel.rd;
  assign fwd_data_o  = sel.data;
`endif
endmodule
